// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter that shares one 8:1 datapath between
// eight requesters and registers the winning beat into a single valid/ready
// output stage (one beat per cycle).
// Optional packet locking is built when MUX8_ARB_LOCK_EN is defined; without
// it every beat is treated as the end of its packet and o_out_last is tied 1.

module mux8 #(
  parameter int WIDTH = 32
) (
  input  logic [8*WIDTH-1:0] i_data,
  input  logic [2:0]         i_sel,
  output logic [WIDTH-1:0]   o_data
);

  // 8:1 selection of one WIDTH-bit lane
  always_comb begin
    case (i_sel)
      3'd0:    o_data = i_data[0*WIDTH +: WIDTH];
      3'd1:    o_data = i_data[1*WIDTH +: WIDTH];
      3'd2:    o_data = i_data[2*WIDTH +: WIDTH];
      3'd3:    o_data = i_data[3*WIDTH +: WIDTH];
      3'd4:    o_data = i_data[4*WIDTH +: WIDTH];
      3'd5:    o_data = i_data[5*WIDTH +: WIDTH];
      3'd6:    o_data = i_data[6*WIDTH +: WIDTH];
      3'd7:    o_data = i_data[7*WIDTH +: WIDTH];
      default: o_data = {WIDTH{1'b0}};
    endcase
  end

endmodule

module mux8_rr_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [7:0]         i_req_valid,
  input  logic [8*WIDTH-1:0] i_req_data,
  input  logic [7:0]         i_req_last,
  output logic [7:0]         o_req_ready,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [WIDTH-1:0]   o_out_data,
  output logic [2:0]         o_out_sel,
  output logic               o_out_last
);

  logic             w_slot_free;
  logic             w_found;
  logic [2:0]       w_scan;
  logic [2:0]       w_rr_win;
  logic [2:0]       w_win;
  logic             w_any;
  logic             w_last;
  logic             w_xfer;
  logic [WIDTH-1:0] w_mux_data;

  logic [2:0]       r_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [2:0]       r_out_sel;

  // A new beat may load when the register is empty or being drained now
  assign w_slot_free = !r_out_valid || i_out_ready;

  // Round-robin scan: first valid requester at r_ptr, r_ptr+1, ... (mod 8)
  always_comb begin
    w_rr_win = r_ptr;
    w_found  = 1'b0;
    w_scan   = r_ptr;
    for (int k = 0; k < 8; k++) begin
      w_scan = r_ptr + 3'(k);
      if (!w_found && i_req_valid[w_scan]) begin
        w_rr_win = w_scan;
        w_found  = 1'b1;
      end else begin
        w_rr_win = w_rr_win;
      end
    end
  end

`ifdef MUX8_ARB_LOCK_EN
  typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_owner;
  logic       r_out_last;

  // While locked only the owner is eligible; otherwise the round-robin winner
  always_comb begin
    if (r_state == LOCKED) begin
      w_win = r_owner;
      w_any = i_req_valid[r_owner];
    end else begin
      w_win = w_rr_win;
      w_any = w_found;
    end
  end

  assign w_last = i_req_last[w_win];

  // FSM state and lock owner registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_owner <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer && !w_last) begin
        r_owner <= w_win;
      end
    end
  end

  // Next state: a non-last beat takes the lock, a last beat releases it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_xfer && !w_last) w_state_nxt = LOCKED;
        else                   w_state_nxt = IDLE;
      end
      LOCKED: begin
        if (w_xfer && w_last) w_state_nxt = IDLE;
        else                  w_state_nxt = LOCKED;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Registered end-of-packet flag travelling with the output beat
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_last <= 1'b0;
    end else if (w_xfer) begin
      r_out_last <= w_last;
    end
  end

  assign o_out_last = r_out_last;
`else
  logic w_unused_last;

  assign w_win         = w_rr_win;
  assign w_any         = w_found;
  assign w_last        = 1'b1;
  assign w_unused_last = ^i_req_last;
  assign o_out_last    = 1'b1;
`endif

  // Grant is one-hot on the eligible winner; never during reset or stall
  always_comb begin
    o_req_ready = 8'd0;
    if (!i_rst && w_any && w_slot_free) begin
      o_req_ready[w_win] = 1'b1;
    end else begin
      o_req_ready = 8'd0;
    end
  end

  assign w_xfer = |(o_req_ready & i_req_valid);

  mux8 #(.WIDTH(WIDTH)) u_mux8 (
    .i_data (i_req_data),
    .i_sel  (w_win),
    .o_data (w_mux_data)
  );

  // Output stage and priority pointer; a new beat overwrites a draining one
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr       <= 3'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= {WIDTH{1'b0}};
      r_out_sel   <= 3'd0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux_data;
      r_out_sel   <= w_win;
      if (w_last) begin
        r_ptr <= w_win + 3'd1;
      end
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: per-cycle vector table (grant and out_valid
// expectations) plus a scoreboard of accepted beats checked at the output.
// Lock-specific vectors are included when MUX8_ARB_LOCK_EN is defined.

module tb_mux8_rr_arbiter;
  localparam int WIDTH = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         req_valid;
  logic [8*WIDTH-1:0] req_data;
  logic [7:0]         req_last;
  logic [7:0]         req_ready;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_sel;
  logic               out_last;

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .i_req_last  (req_last),
    .o_req_ready (req_ready),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_sel   (out_sel),
    .o_out_last  (out_last)
  );

  typedef struct {
    logic       rst;
    logic [7:0] valid;
    logic [7:0] last;
    logic       ordy;
    logic [7:0] exp_ready;
    logic       exp_ov;
  } vec_t;

  typedef struct {
    logic [2:0]       sel;
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  vec_t  vecs[$];
  beat_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic add(input logic r, input logic [7:0] v, input logic [7:0] l,
                     input logic o, input logic [7:0] er, input logic eov);
    vec_t t;
    t.rst = r; t.valid = v; t.last = l; t.ordy = o; t.exp_ready = er; t.exp_ov = eov;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic             prev_hold;
    logic [2:0]       prev_sel;
    logic [WIDTH-1:0] prev_data;
    beat_t            b;

    for (int i = 0; i < 8; i++) req_data[i*WIDTH +: WIDTH] = WIDTH'(100 + i);

    // rotation 0..7,0 with one beat per cycle
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 8'h01, 1'b0);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 8'h02, 1'b1);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 8'h04, 1'b1);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 8'h08, 1'b1);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 8'h10, 1'b1);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 8'h20, 1'b1);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 8'h40, 1'b1);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 8'h80, 1'b1);
    add(1'b0, 8'hFF, 8'hFF, 1'b1, 8'h01, 1'b1);
    add(1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1);
    add(1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b0);
    // wrap and skip: requester 5 moves ptr to 6, then 1 then 2 win
    add(1'b0, 8'h20, 8'hFF, 1'b1, 8'h20, 1'b0);
    add(1'b0, 8'h06, 8'hFF, 1'b1, 8'h02, 1'b1);
    add(1'b0, 8'h06, 8'hFF, 1'b1, 8'h04, 1'b1);
    add(1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1);
    add(1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b0);
    // backpressure: beat from 3 held 3 cycles, then drain+fill with 4
    add(1'b0, 8'h08, 8'hFF, 1'b0, 8'h08, 1'b0);
    add(1'b0, 8'h10, 8'hFF, 1'b0, 8'h00, 1'b1);
    add(1'b0, 8'h10, 8'hFF, 1'b0, 8'h00, 1'b1);
    add(1'b0, 8'h10, 8'hFF, 1'b0, 8'h00, 1'b1);
    add(1'b0, 8'h10, 8'hFF, 1'b1, 8'h10, 1'b1);
    add(1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1);
    add(1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b0);
`ifdef MUX8_ARB_LOCK_EN
    // 3-beat packet from 3 with 4 waiting; 3 idles 2 cycles mid-packet
    add(1'b0, 8'h18, 8'h10, 1'b1, 8'h08, 1'b0);
    add(1'b0, 8'h18, 8'h10, 1'b1, 8'h08, 1'b1);
    add(1'b0, 8'h10, 8'h10, 1'b1, 8'h00, 1'b1);
    add(1'b0, 8'h10, 8'h10, 1'b1, 8'h00, 1'b0);
    add(1'b0, 8'h18, 8'h18, 1'b1, 8'h08, 1'b0);
    add(1'b0, 8'h10, 8'h10, 1'b1, 8'h10, 1'b1);
    add(1'b0, 8'h00, 8'h10, 1'b1, 8'h00, 1'b1);
    add(1'b0, 8'h00, 8'h10, 1'b1, 8'h00, 1'b0);
`endif
    // reset after first beat of a 3 packet: lock dropped, 4 wins, ptr back to 0
    add(1'b0, 8'h18, 8'h10, 1'b1, 8'h08, 1'b0);
    add(1'b1, 8'h18, 8'h10, 1'b0, 8'h00, 1'b1);
    add(1'b0, 8'h10, 8'h10, 1'b1, 8'h10, 1'b0);
    add(1'b0, 8'h08, 8'h08, 1'b1, 8'h08, 1'b1);
    add(1'b0, 8'h00, 8'h08, 1'b1, 8'h00, 1'b1);
    add(1'b0, 8'h00, 8'h08, 1'b1, 8'h00, 1'b0);

    // reset with every requester asking
    rst = 1'b1; req_valid = 8'hFF; req_last = 8'hFF; out_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_ready", 64'(req_ready), 64'h0);
      check("rst_out_valid", 64'(out_valid), 64'h0);
      check("rst_out_data", 64'(out_data), 64'h0);
      check("rst_out_sel", 64'(out_sel), 64'h0);
    end
    @(posedge clk); #1;

    prev_hold = 1'b0;
    prev_sel  = 3'd0;
    prev_data = {WIDTH{1'b0}};
    for (int n = 0; n < vecs.size(); n++) begin
      rst       = vecs[n].rst;
      req_valid = vecs[n].valid;
      req_last  = vecs[n].last;
      out_ready = vecs[n].ordy;
      @(negedge clk);
      check($sformatf("v%0d_ready", n), 64'(req_ready), 64'(vecs[n].exp_ready));
      check($sformatf("v%0d_out_valid", n), 64'(out_valid), 64'(vecs[n].exp_ov));
      if (prev_hold) begin
        check($sformatf("v%0d_hold_sel", n), 64'(out_sel), 64'(prev_sel));
        check($sformatf("v%0d_hold_data", n), 64'(out_data), 64'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check($sformatf("v%0d_unexpected_beat", n), 64'(1), 64'(0));
        end else begin
          b = sb.pop_front();
          check($sformatf("v%0d_out_sel", n), 64'(out_sel), 64'(b.sel));
          check($sformatf("v%0d_out_data", n), 64'(out_data), 64'(b.data));
          check($sformatf("v%0d_out_last", n), 64'(out_last), 64'(b.last));
        end
      end
      if (vecs[n].rst) begin
        sb.delete();
      end else begin
        for (int k = 0; k < 8; k++) begin
          if (vecs[n].exp_ready[k] && vecs[n].valid[k]) begin
            b.sel  = 3'(k);
            b.data = WIDTH'(100 + k);
`ifdef MUX8_ARB_LOCK_EN
            b.last = vecs[n].last[k];
`else
            b.last = 1'b1;
`endif
            sb.push_back(b);
          end
        end
      end
      prev_hold = out_valid && !out_ready && !vecs[n].rst;
      prev_sel  = out_sel;
      prev_data = out_data;
      @(posedge clk); #1;
    end

    check("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and sequencer that shares one 8:1 datapath between eight requesters (e.g. functional-unit results competing for a single writeback/CDB port). It picks a winner each cycle, drives the select of an internal `mux8` instance, and registers the selected payload into a single output stage with valid/ready flow control. Optional packet locking keeps a multi-beat transfer from being interleaved with other requesters.

## Interface
- `WIDTH`, default 32: payload width per requester.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 8: bit i set means requester i has a beat.
- `req_data` input 8*WIDTH: requester i occupies bits [i*WIDTH +: WIDTH].
- `req_last` input 8: bit i marks requester i's current beat as the end of its packet. Used only with `MUX8_ARB_LOCK_EN`.
- `req_ready` output 8: one-hot or zero. Beat i transfers in a cycle where `req_valid[i] & req_ready[i]`.
- `out_valid` output 1: output register holds a beat.
- `out_ready` input 1: consumer accepts the beat.
- `out_data` output WIDTH: registered payload.
- `out_sel` output 3: index of the requester whose beat is in `out_data`.
- `out_last` output 1: registered `req_last` of that beat. Constant 1 without `MUX8_ARB_LOCK_EN`.

## Operation
- **Internal state:**
  - `ptr[2:0]`: round-robin priority pointer.
  - FSM `{IDLE, LOCKED}`.
  - `owner[2:0]`: requester holding the lock.
  - Output register.
- **Slot free:** `slot_free = !out_valid | out_ready`.
- **IDLE arbitration:**
  - The winner is the first set bit of `req_valid`, scanning `ptr`, `ptr+1`, … `ptr+7` modulo 8.
  - If any bit is set and `slot_free`, then `req_ready[winner]=1`.
  - The `mux8` select equals `winner`.
  - The beat loads the output register.
- **LOCKED:**
  - Only `owner` is eligible; every other `req_ready` bit is 0.
  - If `req_valid[owner]` is 0, nothing transfers and the lock is held indefinitely.
- **On a transfer from requester w:**
  - `out_data <= req_data[w]`, `out_sel <= w`, `out_last <= req_last[w]`, `out_valid <= 1`.
  - If `req_last[w]`: state goes to IDLE and `ptr <= w+1` (mod 8, wraps from 7 to 0).
  - Otherwise: state goes to LOCKED and `owner <= w`; `ptr` is unchanged.
- **No transfer but `out_ready`:** `out_valid <= 0`.
- **Simultaneous drain and fill:** when `out_valid & out_ready` coincide with a new transfer, the new beat replaces the old one. Throughput is 1 beat per cycle.
- **`req_ready` dependencies:**
  - `req_ready` is combinational from `req_valid`, state, `ptr` and `out_valid`/`out_ready`.
  - It does not depend on `req_data`.
- **Requester contract:** requesters must not drop `req_valid` or change data before the handshake.
- **Reset values:**
  - `out_valid=0`, `out_data=0`, `out_sel=0`, `out_last=0`.
  - `ptr=0`, state IDLE, `owner=0`.
  - `req_ready=0` while `rst` is high.
- **Reset mid-packet:** the lock is dropped, and the in-flight output beat is discarded without handshake.

## Timing
- Accept to `out_valid` is 1 cycle: the beat accepted at edge n is visible after edge n.
- Output holds stable while `out_valid & !out_ready`.
- `req_ready` is all-zero while the slot is not free.
- Fairness in IDLE: a requester that remains valid is granted within 8 packets.
- With locking, that wait is bounded by 7 other packets.

## Configuration
- **`MUX8_ARB_LOCK_EN` defined:** the LOCKED state, `owner` and `req_last` handling are built as described above.
- **`MUX8_ARB_LOCK_EN` undefined:**
  - The FSM stays IDLE and `req_last` is ignored.
  - Every beat is treated as last, so `ptr <= w+1` after each transfer.
  - `out_last` is tied to 1.

## Test plan
- **Reset:**
  - Stimulus: `rst=1` for 2 cycles with all `req_valid=8'hFF`.
  - Required: `req_ready=0`, `out_valid=0`, `out_data=0`, `out_sel=0`.
  - Stimulus: release `rst`.
  - Required: first grant goes to requester 0; next cycle `out_sel=0`, `out_valid=1`.
- **Round-robin rotation:**
  - Stimulus: `req_valid=8'hFF`, `req_last=8'hFF`, `out_ready=1`, `req_data[i]=i+100`.
  - Required: `out_sel` sequence 0,1,…,7,0; `out_data` sequence 100,…,107,100; one beat per cycle.
- **Wrap and skip:**
  - Stimulus: `ptr=6` (after a requester-5 packet), `req_valid=8'b0000_0110`.
  - Required: requester 1 is granted, then `ptr=2`, then requester 2 is granted.
- **Backpressure:**
  - Stimulus: `out_ready=0` for 3 cycles with a beat held.
  - Required: `out_data`/`out_sel` stable, `req_ready=0`.
  - Stimulus: `out_ready=1`.
  - Required: the held beat drains and the next beat loads in the same cycle.
- **Lock (`MUX8_ARB_LOCK_EN`):**
  - Stimulus: requester 3 sends a 3-beat packet (`last` on the 3rd beat) while requester 4 is valid.
  - Required: `out_sel` sequence 3,3,3,4; requester 3 idle for 2 cycles mid-packet holds the lock with requester 4 still blocked.
- **Reset mid-lock:**
  - Stimulus: `rst` after beat 1 of requester 3's packet.
  - Required: state IDLE, `ptr=0`; requester 4 is granted ahead of requester 3's remaining beats.
